execute_cycle: RTL

//  Execute stage of the 5-stage RV32 pipeline. Consumes the ID/EX signals (*E), resolves forwarding, runs the ALU,

---
 rtl/exec_pkg.sv | 35 +++
 rtl/execute_cycle_if.sv | 33 +++
 rtl/mac_mult_seq.sv | 44 ++++
 rtl/execute_cycle.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the RV32 execute stage: ALU op codes, MUL/MAC FSM states,
// forwarding selects and MAC saturation limits.
package exec_pkg;

   // Datapath width; the multiplier busy time equals XLEN cycles (only 32 is supported).
   localparam int XLEN = 32;

   localparam logic [5:0] OP_ADD    = 6'h00;
   localparam logic [5:0] OP_SUB    = 6'h01;
   localparam logic [5:0] OP_AND    = 6'h02;
   localparam logic [5:0] OP_OR     = 6'h03;
   localparam logic [5:0] OP_SLT    = 6'h05;
   localparam logic [5:0] OP_MUL    = 6'h10;
   localparam logic [5:0] OP_MAC    = 6'h11;
   localparam logic [5:0] OP_MACRD  = 6'h12;
   localparam logic [5:0] OP_MACCLR = 6'h13;

   localparam logic [1:0] FWD_RD = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [XLEN-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [XLEN-1:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   function automatic logic is_mult_op(input logic [5:0] op);
      return (op == OP_MUL) || (op == OP_MAC);
   endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master = upstream pipeline, slave = execute_cycle.
interface execute_cycle_if;
   import exec_pkg::*;

   logic            RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [5:0]      ALUControlE;
   logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]      RD_E;
   logic [1:0]      ForwardAE, ForwardBE;
   logic [XLEN-1:0] ResultW;

   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic            StallE;
   logic            RegWriteM, MemWriteM, ResultSrcM;
   logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]      RD_M;

   modport master (
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
      input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
             ALUResultM, WriteDataM, PCPlus4M, RD_M
   );

   modport slave (
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
      output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
             ALUResultM, WriteDataM, PCPlus4M, RD_M
   );

endinterface

// File: rtl/mac_mult_seq.sv
// Radix-2 shift-add multiplier: one partial product per cycle, yields the low XLEN bits of a*b.
module mac_mult_seq
   import exec_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product
);

   logic [XLEN-1:0] mcand;
   // Remaining multiplier bits with a marker bit above them; the marker reaching bit 0 ends the run.
   logic [XLEN:0]   mplier;

   assign busy = |mplier[XLEN:1];

   // NOTE: non-blocking assignments so every register here samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         done    <= 1'b0;
      end else if (start) begin
         mcand   <= a;
         mplier  <= {1'b1, b};
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            done   <= (mplier[XLEN:2] == '0);
         end
      end
   end

endmodule

// File: rtl/execute_cycle.sv
// RV32 execute stage: forwarding, ALU, branch resolve, EX/MEM register and a stalling MUL/MAC unit.
// Define EXEC_MAC_SAT_EN for signed saturation of the MAC accumulate; otherwise it wraps.
module execute_cycle
   import exec_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   execute_cycle_if.slave bus
);

   localparam int CNT_W = $clog2(XLEN);

   mul_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b;
   logic [XLEN-1:0] alu_res, ex_res, acc, product, raw_sum, mac_sum;
   logic            stall, mult_start, mult_busy, mult_done, is_mult;

   always_comb begin
      case (bus.ForwardAE)
         FWD_W:   fwd_a = bus.ResultW;
         FWD_M:   fwd_a = bus.ALUResultM;
         default: fwd_a = bus.RD1_E;
      endcase
      case (bus.ForwardBE)
         FWD_W:   fwd_b = bus.ResultW;
         FWD_M:   fwd_b = bus.ALUResultM;
         default: fwd_b = bus.RD2_E;
      endcase
   end

   assign src_a   = fwd_a;
   assign src_b   = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
   assign is_mult = is_mult_op(bus.ALUControlE);

   always_comb begin
      case (bus.ALUControlE)
         OP_ADD:    alu_res = src_a + src_b;
         OP_SUB:    alu_res = src_a - src_b;
         OP_AND:    alu_res = src_a & src_b;
         OP_OR:     alu_res = src_a | src_b;
         OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_MACRD:  alu_res = acc;
         OP_MACCLR: alu_res = '0;
         default:   alu_res = '0;
      endcase
   end

   assign raw_sum = acc + product;
`ifdef EXEC_MAC_SAT_EN
   logic mac_ovf;
   // Overflow only when both addends share a sign that the sum does not.
   assign mac_ovf = (acc[XLEN-1] == product[XLEN-1]) && (raw_sum[XLEN-1] != acc[XLEN-1]);
   assign mac_sum = mac_ovf ? (acc[XLEN-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
   assign mac_sum = raw_sum;
`endif

   assign ex_res = (state == ST_DONE) ?
                   ((bus.ALUControlE == OP_MAC) ? mac_sum : product) : alu_res;

   assign bus.PCSrcE    = bus.BranchE & (src_a == src_b) & (state == ST_IDLE);
   assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
   assign bus.StallE    = stall;

   // NOTE: defaults assigned first so no path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      stall      = 1'b0;
      mult_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_mult) begin
               stall = 1'b1;
               if (!mult_busy) begin
                  mult_start = 1'b1;
                  state_nxt  = ST_BUSY;
                  cnt_nxt    = '0;
               end
            end
         end
         ST_BUSY: begin
            stall   = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Operands are captured at issue: M/W hold bubbles while the multiply runs.
   mac_mult_seq u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (mult_start),
      .a       (fwd_a),
      .b       (fwd_b),
      .busy    (mult_busy),
      .done    (mult_done),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if ((state == ST_IDLE) && (bus.ALUControlE == OP_MACCLR)) begin
         acc <= '0;
      end else if ((state == ST_DONE) && (bus.ALUControlE == OP_MAC) && mult_done) begin
         acc <= mac_sum;
      end
   end

   // EX/MEM: bubbles clear only the control bits; data fields hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.RegWriteM  <= 1'b0;
         bus.MemWriteM  <= 1'b0;
         bus.ResultSrcM <= 1'b0;
         bus.ALUResultM <= '0;
         bus.WriteDataM <= '0;
         bus.PCPlus4M   <= '0;
         bus.RD_M       <= '0;
      end else if (stall) begin
         bus.RegWriteM  <= 1'b0;
         bus.MemWriteM  <= 1'b0;
         bus.ResultSrcM <= 1'b0;
      end else begin
         bus.RegWriteM  <= bus.RegWriteE;
         bus.MemWriteM  <= bus.MemWriteE;
         bus.ResultSrcM <= bus.ResultSrcE;
         bus.ALUResultM <= ex_res;
         bus.WriteDataM <= fwd_b;
         bus.PCPlus4M   <= bus.PCPlus4E;
         bus.RD_M       <= bus.RD_E;
      end
   end

endmodule
